// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port data memory between the instruction-fetch requester
// and the load/store requester. One request is accepted at a time, issued to
// the memory for a single cycle, and for reads the fixed memory latency is
// timed so the read data returns to the requester that issued it.
//
// Sequence: IDLE -> ISSUE -> (WAIT for reads) -> IDLE.
//   request seen in cycle N -> gnt + mem strobe in N+1
//   read:  rvalid in N+RD_LAT+2
//   store: back in IDLE in N+2
//
// Parameters
//   ADDR_W  address width (requesters and memory)
//   DATA_W  data width
//   RD_LAT  memory read latency in cycles, 1..15 (4-bit latency counter)
//
// Ports
//   clk, reset            clock (rising edge), synchronous active-high reset
//   if_req/if_addr        fetch read request (held until if_gnt)
//   if_gnt                1-cycle pulse: fetch issued to memory
//   if_rvalid/if_rdata    1-cycle pulse + registered fetch read data
//   d_req/d_we/d_addr/d_wdata  load/store request (held until d_gnt)
//   d_gnt                 1-cycle pulse: load/store issued to memory
//   d_rvalid/d_rdata      1-cycle pulse + registered load data
//   mem_addr/mem_wdata    registered memory address / write data
//   mem_wr/mem_rd         1-cycle memory strobes, never both high
//   mem_rdata             memory read data, valid RD_LAT cycles after mem_rd
//   busy                  high whenever the sequencer is not idle
//
// Configuration macro
//   ARB_ROUND_ROBIN_EN  defined: on a tie, grant the requester that did not
//                       own the previous transaction.
//                       undefined: fixed priority, load/store wins every tie.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  // instruction-fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // load/store requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic       OWNER_FETCH = 1'b0;
  localparam logic       OWNER_DATA  = 1'b1;
  localparam logic [3:0] RD_LAT_CNT  = 4'(RD_LAT);

  state_t     state_reg;
  logic [3:0] lat_cnt_reg;
  logic       we_reg;      // latched transaction is a store
  logic       owner_reg;   // latched transaction owner (OWNER_*)
  logic       pick_data;   // arbitration result for the current IDLE cycle

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_reg;

  // On a tie, hand the memory to whoever did not have it last time.
  always_comb begin
    pick_data = d_req;
    if (d_req && if_req) begin
      pick_data = (last_owner_reg == OWNER_FETCH);
    end
  end
`else
  // Fixed priority: a pending load/store always finishes before the next fetch.
  assign pick_data = d_req;
`endif

  assign busy = (state_reg != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      lat_cnt_reg <= 4'd0;
      we_reg      <= 1'b0;
      owner_reg   <= OWNER_FETCH;
      if_gnt      <= 1'b0;
      if_rvalid   <= 1'b0;
      if_rdata    <= '0;
      d_gnt       <= 1'b0;
      d_rvalid    <= 1'b0;
      d_rdata     <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_reg <= OWNER_FETCH;
`endif
    end else begin
      // All strobes and pulses default low; each is raised for one cycle only.
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_wr    <= 1'b0;
      mem_rd    <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (if_req || d_req) begin
            // The winner's address/data are captured straight into the
            // registered memory outputs, so they appear during ISSUE together
            // with the strobe and the grant pulse.
            owner_reg <= pick_data ? OWNER_DATA : OWNER_FETCH;
            we_reg    <= pick_data & d_we;
            mem_addr  <= pick_data ? d_addr : if_addr;
            mem_wdata <= pick_data ? d_wdata : '0;
            mem_wr    <= pick_data & d_we;
            mem_rd    <= ~(pick_data & d_we);
            d_gnt     <= pick_data;
            if_gnt    <= ~pick_data;
            state_reg <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
`ifdef ARB_ROUND_ROBIN_EN
          last_owner_reg <= owner_reg;
`endif
          if (we_reg) begin
            lat_cnt_reg <= 4'd0;
            state_reg   <= ST_IDLE;
          end else begin
            // Counting starts at 1 in the first WAIT cycle, so reaching RD_LAT
            // lines up with the cycle in which mem_rdata becomes valid.
            lat_cnt_reg <= 4'd1;
            state_reg   <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (lat_cnt_reg == RD_LAT_CNT) begin
            if (owner_reg == OWNER_DATA) begin
              d_rdata  <= mem_rdata;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end
            lat_cnt_reg <= 4'd0;
            state_reg   <= ST_IDLE;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 4'd1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter (RD_LAT = 2). A behavioural memory
// answers mem_rd after RD_LAT cycles. Every request driven pushes its expected
// grant (and, for reads, its expected read return) onto scoreboard queues; a
// negedge monitor pops and compares them as the DUT produces gnt/rvalid.
// A vector table covers single transactions; hand-written sequences cover
// simultaneous requests, held requests and reset during a read.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        busy;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural memory (64 words, addr[7:2]) ----------------
  logic [31:0] bmem [64];
  bit          rd_v [RD_LAT];
  logic [31:0] rd_d [RD_LAT];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) bmem[i] <= 32'h0;
      bmem[0]  <= 32'hFFFF_FFFF;
      bmem[4]  <= 32'hE3A0_1005;
      bmem[17] <= 32'h1234_5678;
      for (int i = 0; i < RD_LAT; i++) rd_v[i] <= 1'b0;
    end else begin
      rd_v[0] <= mem_rd;
      rd_d[0] <= bmem[mem_addr[7:2]];
      for (int i = 1; i < RD_LAT; i++) begin
        rd_v[i] <= rd_v[i-1];
        rd_d[i] <= rd_d[i-1];
      end
      if (mem_wr) bmem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  assign mem_rdata = rd_v[RD_LAT-1] ? rd_d[RD_LAT-1] : 32'hBAD0_BAD0;

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } gexp_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    int          cyc;
  } rexp_t;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_busy_n2;  // busy two cycles after the request
  } vec_t;

  gexp_t       gq[$];
  rexp_t       rq[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          inv_viol = 0;
  logic [31:0] i_rdata_m = 32'h0;
  logic [31:0] d_rdata_m = 32'h0;
  bit          last_owner_m = 1'b0;  // 1 = data owned the last grant

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_req(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata_exp,
                          input int gcyc);
    gexp_t g;
    rexp_t r;
    g.is_d = is_d; g.we = we; g.addr = addr; g.wdata = wdata; g.cyc = gcyc;
    gq.push_back(g);
    if (!we) begin
      r.is_d = is_d; r.rdata = rdata_exp; r.cyc = gcyc + RD_LAT + 1;
      rq.push_back(r);
    end
    last_owner_m = is_d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"}, {if_rdata, d_rdata}, 64'h0);
    check({tag, "_mem"}, {mem_addr, mem_wdata}, 64'h0);
    check({tag, "_ctrl"}, 64'({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_rd, mem_wr, busy}), 64'h0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    bit    prev_ig = 1'b0;
    bit    prev_dg = 1'b0;
    gexp_t g;
    rexp_t r;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ig = 1'b0;
        prev_dg = 1'b0;
      end else begin
        if (mem_rd && mem_wr) inv_viol++;
        if ((mem_rd || mem_wr) && !(if_gnt || d_gnt)) inv_viol++;
        if (if_gnt && d_gnt) inv_viol++;
        if ((if_gnt && prev_ig) || (d_gnt && prev_dg)) inv_viol++;
        prev_ig = if_gnt;
        prev_dg = d_gnt;

        if (if_gnt || d_gnt) begin
          if (gq.size() == 0) begin
            check("unexpected_gnt", 64'({if_gnt, d_gnt}), 64'h0);
          end else begin
            g = gq.pop_front();
            $display("[TB] cyc %0d gnt %s %s addr=0x%08h wdata=0x%08h", cyc,
                     d_gnt ? "data " : "fetch", mem_wr ? "wr" : "rd", mem_addr, mem_wdata);
            check("gnt_owner", 64'({if_gnt, d_gnt}), g.is_d ? 64'd1 : 64'd2);
            check("gnt_cycle", 64'(cyc), 64'(g.cyc));
            check("mem_addr", 64'(mem_addr), 64'(g.addr));
            check("mem_wr", 64'(mem_wr), 64'(g.we));
            check("mem_rd", 64'(mem_rd), 64'(!g.we));
            if (g.we) check("mem_wdata", 64'(mem_wdata), 64'(g.wdata));
          end
        end

        if (if_rvalid || d_rvalid) begin
          if (rq.size() == 0) begin
            check("unexpected_rvalid", 64'({if_rvalid, d_rvalid}), 64'h0);
          end else begin
            r = rq.pop_front();
            $display("[TB] cyc %0d rvalid %s rdata=0x%08h", cyc,
                     d_rvalid ? "data " : "fetch", d_rvalid ? d_rdata : if_rdata);
            check("rvalid_owner", 64'({if_rvalid, d_rvalid}), r.is_d ? 64'd1 : 64'd2);
            check("rvalid_cycle", 64'(cyc), 64'(r.cyc));
            if (r.is_d) begin
              check("d_rdata", 64'(d_rdata), 64'(r.rdata));
              check("if_rdata_hold", 64'(if_rdata), 64'(i_rdata_m));
              d_rdata_m = r.rdata;
            end else begin
              check("if_rdata", 64'(if_rdata), 64'(r.rdata));
              check("d_rdata_hold", 64'(d_rdata), 64'(d_rdata_m));
              i_rdata_m = r.rdata;
            end
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_drain();
    bit done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (gq.size() == 0 && rq.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    check("drain", 64'(done), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    bit got = 1'b0;
    @(posedge clk);
    #1;
    push_req(v.is_d, v.we, v.addr, v.wdata, v.exp_rdata, cyc + 1);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (v.is_d ? d_gnt : if_gnt) begin
        got = 1'b1;
        break;
      end
    end
    check("gnt_seen", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    d_req  = 1'b0;
    @(negedge clk);
    check("busy_n2", 64'(busy), 64'(v.exp_busy_n2));
    wait_drain();
  endtask

  function automatic bit tie_pick_data();
`ifdef ARB_ROUND_ROBIN_EN
    return !last_owner_m;
`else
    return 1'b1;
`endif
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  vec_t vecs [11];

  initial begin
    int n;
    bit ig_seen;
    bit dg_seen;
    int gcount;
    bit first_d;
    bit nd;

    //            is_d we  addr          wdata          exp_rdata      busy@N+2
    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hE3A0_1005, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h5555_AAAA, 32'hDEAD_BEEF, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,         32'h1234_5678, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hE3A0_1005, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,         1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_00FC, 32'h0000_0001, 32'h0,         1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0,         32'h0000_0001, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'hFFFF_FFFF, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h0000_0000, 1'b1};

    reset = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // single transactions, one per table row
    foreach (vecs[i]) run_vec(vecs[i]);

    // both requests in the same IDLE cycle (loads to 0x40 / fetch of 0x10)
    @(posedge clk);
    #1;
    n = cyc;
    first_d = tie_pick_data();
    push_req(first_d, 1'b0, first_d ? 32'h40 : 32'h10, 32'h0,
             first_d ? 32'hDEAD_BEEF : 32'hCAFE_F00D, n + 1);
    push_req(!first_d, 1'b0, !first_d ? 32'h40 : 32'h10, 32'h0,
             !first_d ? 32'hDEAD_BEEF : 32'hCAFE_F00D, n + RD_LAT + 3);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    if_req = 1'b1; if_addr = 32'h10;
    ig_seen = 1'b0; dg_seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (if_gnt) ig_seen = 1'b1;
      if (d_gnt)  dg_seen = 1'b1;
      @(posedge clk);
      #1;
      if (ig_seen) if_req = 1'b0;
      if (dg_seen) d_req = 1'b0;
      if (ig_seen && dg_seen) break;
    end
    check("tie_both_granted", 64'({ig_seen, dg_seen}), 64'd3);
    if_req = 1'b0; d_req = 1'b0;
    wait_drain();

    // both requests held for four grants
    @(posedge clk);
    #1;
    n = cyc;
    for (int t = 0; t < 4; t++) begin
      nd = tie_pick_data();
      push_req(nd, 1'b0, nd ? 32'h40 : 32'h10, 32'h0,
               nd ? 32'hDEAD_BEEF : 32'hCAFE_F00D, n + 1 + t * (RD_LAT + 2));
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    if_req = 1'b1; if_addr = 32'h10;
    gcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) gcount++;
      if (gcount == 4) break;
    end
    check("held_grant_count", 64'(gcount), 64'd4);
    @(posedge clk);
    #1;
    if_req = 1'b0; d_req = 1'b0;
    wait_drain();

    // reset during the WAIT of a fetch read: no rvalid may follow
    @(posedge clk);
    #1;
    n = cyc;
    begin
      gexp_t g;
      g.is_d = 1'b0; g.we = 1'b0; g.addr = 32'h10; g.wdata = 32'h0; g.cyc = n + 1;
      gq.push_back(g);
    end
    if_req = 1'b1; if_addr = 32'h10;
    @(posedge clk);
    #1;                     // cycle n+1: ISSUE
    @(posedge clk);
    #1;                     // cycle n+2: WAIT
    if_req = 1'b0;
    check("busy_in_wait", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    i_rdata_m = 32'h0;
    d_rdata_m = 32'h0;
    last_owner_m = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    check("midreset_gq_empty", 64'(gq.size()), 64'd0);
    repeat (6) @(negedge clk);  // monitor flags any stray rvalid here

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0, 32'h1234_5678, 1'b1};
    run_vec(vecs[0]);

    check("invariants", 64'(inv_viol), 64'd0);
    check("queues_empty", 64'(gq.size() + rq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
